// File: rtl/gs232c_ras_pkg.sv
// Shared types for the RAS branch queue: entry record, init length, FSM states.
package gs232c_ras_pkg;
  localparam int RAS_DEPTH = 16;
  localparam int RAS_PCW   = 30;

  typedef struct packed {
    logic               link;
    logic               jrra;
    logic [RAS_PCW-1:0] pc;
    logic               resolved;
  } ras_ent_t;

  typedef enum logic {INIT, RUN} ras_state_t;
endpackage

// File: rtl/gs232c_ras_brq_ptr.sv
// Wrap-around queue pointer, one bit wider than the slot index so full/empty differ.
module gs232c_ras_brq_ptr #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);
  always_ff @(posedge clock) begin
    if (!resetn)   q <= '0;
    else if (load) q <= load_val;
    else if (inc)  q <= q + W'(1);
  end
endmodule

// File: rtl/gs232c_ras_brq.sv
// In-order call/return queue feeding the RAS predictor's decode, resolve and
// commit update ports; also strobes the RAS stack clear after reset.
module gs232c_ras_brq
  import gs232c_ras_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PCW   = RAS_PCW
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_link,
  input  logic                     in_jrra,
  input  logic [PCW-1:0]           in_link_pc,
  output logic [$clog2(DEPTH)-1:0] in_id,
  input  logic                     ex_valid,
  input  logic                     ex_link,
  input  logic                     ex_jrra,
  input  logic                     ex_flush,
  input  logic                     cm_valid,
  input  logic                     cm_flush,
  output logic                     pr_link,
  output logic                     pr_jrra,
  output logic [PCW-1:0]           pr_link_pc,
  output logic                     br_link,
  output logic                     br_jrra,
  output logic [PCW-1:0]           br_link_pc,
  output logic                     br_cancel,
  output logic                     wb_link,
  output logic                     wb_jrra,
  output logic [PCW-1:0]           wb_link_pc,
  output logic                     wb_cancel,
  output logic                     raminit_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(RAS_DEPTH);

  ras_state_t state, state_nxt;
  logic [CW-1:0] init_cnt;

  logic [PW-1:0] hd, rp, tl, hd_post, count, tl_val;
  logic run, full, accept, ex_ok, cm_ok, head_ok, rp_load, tl_load;
  ras_ent_t ent [DEPTH];
  ras_ent_t hd_ent, rp_ent;

  // The counter only advances while the strobe is visible, so the clear
  // covers exactly RAS_DEPTH cycles after reset release.
  always_comb begin
    state_nxt = state;
    if (state == INIT && raminit_valid && init_cnt == CW'(RAS_DEPTH - 1))
      state_nxt = RUN;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= INIT;
      init_cnt      <= '0;
      raminit_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      raminit_valid <= (state_nxt == INIT);
      if (raminit_valid) init_cnt <= init_cnt + CW'(1);
    end
  end

  assign run     = (state == RUN);
  assign hd_ent  = ent[hd[AW-1:0]];
  assign rp_ent  = ent[rp[AW-1:0]];
  assign count   = tl - hd;
  assign full    = (count == PW'(DEPTH));
  assign head_ok = (hd != tl) && hd_ent.resolved;

  assign in_ready = run && !full;
  assign in_id    = tl[AW-1:0];
  assign accept   = in_valid && in_ready && !ex_flush && !cm_flush;
  assign ex_ok    = run && ex_valid && (rp != tl);
  assign cm_ok    = run && cm_valid && head_ok;
  assign hd_post  = hd + PW'(cm_ok);

  // A decode slot flagged both call and return is treated as a return.
  assign pr_link    = accept && in_link && !in_jrra;
  assign pr_jrra    = accept && in_jrra;
  assign pr_link_pc = in_link_pc;

  // Commit flush collapses everything onto the post-retire head; a branch
  // flush trims back to the post-resolve resolve pointer.
  assign rp_load = run && cm_flush;
  assign tl_load = run && (cm_flush || ex_flush);
  assign tl_val  = cm_flush ? hd_post : rp + PW'(ex_ok);

  gs232c_ras_brq_ptr #(.W(PW)) u_hd (
    .clock(clock), .resetn(resetn), .inc(cm_ok), .load(1'b0),
    .load_val('0), .q(hd));
  gs232c_ras_brq_ptr #(.W(PW)) u_rp (
    .clock(clock), .resetn(resetn), .inc(ex_ok), .load(rp_load),
    .load_val(hd_post), .q(rp));
  gs232c_ras_brq_ptr #(.W(PW)) u_tl (
    .clock(clock), .resetn(resetn), .inc(accept), .load(tl_load),
    .load_val(tl_val), .q(tl));

  // Enqueue and resolve never hit the same slot: that needs a full queue,
  // which blocks the enqueue.
  always_ff @(posedge clock) begin
    if (accept)
      ent[tl[AW-1:0]] <= '{link: in_link && !in_jrra, jrra: in_jrra,
                           pc: RAS_PCW'(in_link_pc), resolved: 1'b0};
    if (ex_ok) begin
      ent[rp[AW-1:0]].link     <= ex_link;
      ent[rp[AW-1:0]].jrra     <= ex_jrra;
      ent[rp[AW-1:0]].resolved <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      br_link    <= 1'b0;
      br_jrra    <= 1'b0;
      br_link_pc <= '0;
      br_cancel  <= 1'b0;
      wb_link    <= 1'b0;
      wb_jrra    <= 1'b0;
      wb_link_pc <= '0;
      wb_cancel  <= 1'b0;
    end else begin
      br_link    <= ex_ok && ex_link;
      br_jrra    <= ex_ok && ex_jrra;
      br_link_pc <= ex_ok ? PCW'(rp_ent.pc) : '0;
      br_cancel  <= run && (ex_flush || cm_flush);
      wb_link    <= cm_ok && hd_ent.link;
      wb_jrra    <= cm_ok && hd_ent.jrra;
      wb_link_pc <= cm_ok ? PCW'(hd_ent.pc) : '0;
      wb_cancel  <= run && cm_flush;
    end
  end

  always_ff @(posedge clock) begin
    if (resetn && run && cm_valid)
      assert (head_ok) else $warning("commit on empty queue or unresolved head ignored");
  end
endmodule

// File: tb/tb_gs232c_ras_brq.sv
// Directed vector bench for gs232c_ras_brq: init sequence, fill/full, resolve,
// commit, both flush kinds, pointer wrap, illegal ops and mid-run reset.
module tb_gs232c_ras_brq;
  localparam int DEPTH = 8;
  localparam int PCW   = 30;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic in_valid = 0, in_link = 0, in_jrra = 0;
  logic [PCW-1:0] in_link_pc = '0;
  logic ex_valid = 0, ex_link = 0, ex_jrra = 0, ex_flush = 0;
  logic cm_valid = 0, cm_flush = 0;
  logic in_ready, pr_link, pr_jrra, br_link, br_jrra, br_cancel;
  logic wb_link, wb_jrra, wb_cancel, raminit_valid;
  logic [2:0] in_id;
  logic [PCW-1:0] pr_link_pc, br_link_pc, wb_link_pc;

  always #5 clock = ~clock;

  gs232c_ras_brq #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_link(in_link),
    .in_jrra(in_jrra), .in_link_pc(in_link_pc), .in_id(in_id),
    .ex_valid(ex_valid), .ex_link(ex_link), .ex_jrra(ex_jrra),
    .ex_flush(ex_flush), .cm_valid(cm_valid), .cm_flush(cm_flush),
    .pr_link(pr_link), .pr_jrra(pr_jrra), .pr_link_pc(pr_link_pc),
    .br_link(br_link), .br_jrra(br_jrra), .br_link_pc(br_link_pc),
    .br_cancel(br_cancel), .wb_link(wb_link), .wb_jrra(wb_jrra),
    .wb_link_pc(wb_link_pc), .wb_cancel(wb_cancel),
    .raminit_valid(raminit_valid));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic iv, il, ij;
    logic [PCW-1:0] ipc;
    logic ev, el, ej, ef, cv, cf;
    logic rdy;
    logic [2:0] id;
    logic prl, prj;
    logic brl, brj, brc;
    logic [PCW-1:0] brpc;
    logic wbl, wbj, wbc;
    logic [PCW-1:0] wbpc;
  } vec_t;

  // ik={iv,il,ij} ek={ev,el,ej,ef} ck={cv,cf} pr={prl,prj} br={brl,brj,brc} wb={wbl,wbj,wbc}
  function automatic vec_t mk(input int ik, input int ipc, input int ek, input int ck,
                              input int rdy, input int id, input int pr, input int br,
                              input int brpc, input int wb, input int wbpc);
    vec_t v;
    v.iv = ik[2]; v.il = ik[1]; v.ij = ik[0]; v.ipc = PCW'(ipc);
    v.ev = ek[3]; v.el = ek[2]; v.ej = ek[1]; v.ef = ek[0];
    v.cv = ck[1]; v.cf = ck[0];
    v.rdy = rdy[0]; v.id = id[2:0]; v.prl = pr[1]; v.prj = pr[0];
    v.brl = br[2]; v.brj = br[1]; v.brc = br[0]; v.brpc = PCW'(brpc);
    v.wbl = wb[2]; v.wbj = wb[1]; v.wbc = wb[0]; v.wbpc = PCW'(wbpc);
    return v;
  endfunction

  // Called just after a rising edge: drive, check decode-side outputs, then
  // check the registered outputs one edge later.
  task automatic apply(input vec_t v, input string tag);
    in_valid = v.iv; in_link = v.il; in_jrra = v.ij; in_link_pc = v.ipc;
    ex_valid = v.ev; ex_link = v.el; ex_jrra = v.ej; ex_flush = v.ef;
    cm_valid = v.cv; cm_flush = v.cf;
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(v.rdy));
    chk({tag, ".in_id"},    64'(in_id),    64'(v.id));
    chk({tag, ".pr_link"},  64'(pr_link),  64'(v.prl));
    chk({tag, ".pr_jrra"},  64'(pr_jrra),  64'(v.prj));
    if (v.iv) chk({tag, ".pr_link_pc"}, 64'(pr_link_pc), 64'(v.ipc));
    @(posedge clock); #1;
    chk({tag, ".br_link"},    64'(br_link),    64'(v.brl));
    chk({tag, ".br_jrra"},    64'(br_jrra),    64'(v.brj));
    chk({tag, ".br_link_pc"}, 64'(br_link_pc), 64'(v.brpc));
    chk({tag, ".br_cancel"},  64'(br_cancel),  64'(v.brc));
    chk({tag, ".wb_link"},    64'(wb_link),    64'(v.wbl));
    chk({tag, ".wb_jrra"},    64'(wb_jrra),    64'(v.wbj));
    chk({tag, ".wb_link_pc"}, 64'(wb_link_pc), 64'(v.wbpc));
    chk({tag, ".wb_cancel"},  64'(wb_cancel),  64'(v.wbc));
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_link = 0; in_jrra = 0; in_link_pc = '0;
    ex_valid = 0; ex_link = 0; ex_jrra = 0; ex_flush = 0;
    cm_valid = 0; cm_flush = 0;
  endtask

  task automatic init_seq(input string tag);
    resetn = 1'b1;
    in_valid = 1; in_link = 1; ex_valid = 1; ex_link = 1; cm_valid = 1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock); #1;
      chk($sformatf("%s.raminit_c%0d", tag, k), 64'(raminit_valid), 64'd1);
      chk($sformatf("%s.in_ready_c%0d", tag, k), 64'(in_ready), 64'd0);
      chk($sformatf("%s.pr_link_c%0d", tag, k), 64'(pr_link), 64'd0);
      chk($sformatf("%s.br_link_c%0d", tag, k), 64'(br_link), 64'd0);
      chk($sformatf("%s.wb_link_c%0d", tag, k), 64'(wb_link), 64'd0);
    end
    idle_inputs();
    @(posedge clock); #1;
    chk({tag, ".raminit_c17"}, 64'(raminit_valid), 64'd0);
    chk({tag, ".in_ready_c17"}, 64'(in_ready), 64'd1);
    chk({tag, ".in_id_c17"}, 64'(in_id), 64'd0);
  endtask

  vec_t tbl[$];

  initial begin
    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst.raminit", 64'(raminit_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.in_id", 64'(in_id), 64'd0);
    chk("rst.pr_link", 64'(pr_link), 64'd0);
    chk("rst.br_link", 64'(br_link), 64'd0);
    chk("rst.br_cancel", 64'(br_cancel), 64'd0);
    chk("rst.wb_link", 64'(wb_link), 64'd0);
    chk("rst.wb_cancel", 64'(wb_cancel), 64'd0);

    init_seq("init");

    // fill to full, then blocked enqueue with resolve and commit
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk('b110, 'h100 + i, 0, 0, 1, i, 'b10, 0, 0, 0, 0));
    tbl.push_back(mk('b110, 'h108, 'b1100, 'b00, 0, 0, 'b00, 'b100, 'h100, 0, 0));
    tbl.push_back(mk('b110, 'h108, 0, 'b10, 0, 0, 'b00, 0, 0, 'b100, 'h100));
    // commit flush drains the rest and drops the enqueue
    tbl.push_back(mk('b110, 'h109, 0, 'b01, 1, 0, 'b00, 'b001, 0, 'b001, 0));
    // call then (call+return treated as return), resolve both, commit both
    tbl.push_back(mk('b110, 'h200, 0, 0, 1, 1, 'b10, 0, 0, 0, 0));
    tbl.push_back(mk('b111, 'h2AA, 0, 0, 1, 2, 'b01, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 'b1100, 0, 1, 3, 0, 'b100, 'h200, 0, 0));
    tbl.push_back(mk(0, 0, 'b1010, 0, 1, 3, 0, 'b010, 'h2AA, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'b10, 1, 3, 0, 0, 0, 'b100, 'h200));
    tbl.push_back(mk(0, 0, 0, 'b10, 1, 3, 0, 0, 0, 'b010, 'h2AA));
    // branch flush: 4 entries, 1 resolved, flush with resolve of entry 1
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk('b110, 'h300 + i, 0, 0, 1, 3 + i, 'b10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 'b1100, 0, 1, 7, 0, 'b100, 'h300, 0, 0));
    tbl.push_back(mk('b110, 'h3FF, 'b1011, 0, 1, 7, 'b00, 'b011, 'h301, 0, 0));
    tbl.push_back(mk('b110, 'h400, 0, 0, 1, 5, 'b10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'b10, 1, 6, 0, 0, 0, 'b100, 'h300));
    // commit flush with same-cycle commit, resolve and enqueue
    tbl.push_back(mk('b110, 'h500, 'b1100, 'b11, 1, 6, 'b00, 'b101, 'h400, 'b011, 'h301));
    tbl.push_back(mk('b110, 'h600, 0, 0, 1, 5, 'b10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 'b1100, 0, 1, 6, 0, 'b100, 'h600, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'b10, 1, 6, 0, 0, 0, 'b100, 'h600));
    // 40 overlapped enqueue/resolve/commit triples, ids wrap
    for (int j = 0; j < 42; j++) begin
      int iv, ev, cv;
      iv = (j < 40) ? 1 : 0;
      ev = (j >= 1 && j <= 40) ? 1 : 0;
      cv = (j >= 2) ? 1 : 0;
      tbl.push_back(mk(iv * 'b110, 'h1000 + j, ev * 'b1100, cv * 'b10, 1,
                       (6 + ((j < 40) ? j : 40)) % 8, iv * 'b10,
                       ev * 'b100, ev ? 'h1000 + j - 1 : 0,
                       cv * 'b100, cv ? 'h1000 + j - 2 : 0));
    end
    // commit on unresolved head is ignored; resolve on empty is ignored
    tbl.push_back(mk('b110, 'h777, 0, 0, 1, 6, 'b10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'b10, 1, 7, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 'b1100, 0, 1, 7, 0, 'b100, 'h777, 0, 0));
    tbl.push_back(mk(0, 0, 'b1100, 'b10, 1, 7, 0, 0, 0, 'b100, 'h777));
    tbl.push_back(mk('b110, 'h8AA, 0, 0, 1, 7, 'b10, 0, 0, 0, 0));
    tbl.push_back(mk('b110, 'h8BB, 0, 0, 1, 0, 'b10, 0, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // reset mid-operation with a resolve and commit pending
    idle_inputs();
    resetn = 1'b0;
    ex_valid = 1; ex_link = 1; cm_valid = 1;
    @(posedge clock); #1;
    chk("mrst.br_link", 64'(br_link), 64'd0);
    chk("mrst.br_link_pc", 64'(br_link_pc), 64'd0);
    chk("mrst.br_cancel", 64'(br_cancel), 64'd0);
    chk("mrst.wb_link", 64'(wb_link), 64'd0);
    chk("mrst.raminit", 64'(raminit_valid), 64'd0);
    chk("mrst.in_ready", 64'(in_ready), 64'd0);
    chk("mrst.in_id", 64'(in_id), 64'd0);
    idle_inputs();
    init_seq("reinit");
    apply(mk('b110, 'h9C0, 0, 0, 1, 0, 'b10, 0, 0, 0, 0), "post");
    apply(mk(0, 0, 'b1100, 0, 1, 1, 0, 'b100, 'h9C0, 0, 0), "post_res");
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
